// File: rtl/lpif_arb_pkg.sv
// Shared types and constants for the LPIF upstream protid arbiter.
package lpif_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1
    } arb_state_e;

    // Bit positions inside arb_status: {grant_idx, state, beat_cnt, 20'h0}
    localparam int STAT_GRANT_LSB = 30;
    localparam int STAT_STATE_LSB = 28;
    localparam int STAT_BCNT_LSB  = 20;

    function automatic logic [1:0] next_idx(input logic [1:0] idx, input int num_req);
        return (int'(idx) == num_req - 1) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/lpif_ustrm_protid_arb_if.sv
// Requester-side handshake plus the shared ustrm channel driven by the arbiter.
interface lpif_ustrm_protid_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 256,
    parameter int CRC_WIDTH  = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*CRC_WIDTH-1:0]  req_crc;
    logic [NUM_REQ-1:0]            req_crc_valid;
    logic [NUM_REQ-1:0]            req_ready;

    logic [1:0]                    ustrm_protid;
    logic [DATA_WIDTH-1:0]         ustrm_data;
    logic                          ustrm_dvalid;
    logic [CRC_WIDTH-1:0]          ustrm_crc;
    logic                          ustrm_crc_valid;
    logic                          ustrm_valid;

    modport slave (
        input  req_valid, req_last, req_data, req_crc, req_crc_valid,
        output req_ready,
        output ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid
    );

    modport master (
        output req_valid, req_last, req_data, req_crc, req_crc_valid,
        input  req_ready,
        input  ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid
    );
endinterface

// File: rtl/lpif_ustrm_protid_arb_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, searching cyclically.
module lpif_rr_pick
    import lpif_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         gnt_idx,
    output logic               any_req
);
    logic [MAX_REQ-1:0] req_pad;
    logic [1:0]         idx;

    assign req_pad = MAX_REQ'(req);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_idx = ptr;
        any_req = 1'b0;
        idx     = ptr;
        // Walk from the farthest offset back so the nearest request after ptr wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = 2'((int'(ptr) + off) % NUM_REQ);
            if (req_pad[idx]) begin
                gnt_idx = idx;
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lpif_ustrm_protid_arb.sv
// Packet-granular round-robin arbiter sharing the single LPIF upstream channel among
// up to four protocol requesters; the ustrm side has no backpressure, so req_ready is the only throttle.
module lpif_ustrm_protid_arb
    import lpif_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 256,
    parameter int CRC_WIDTH     = 8,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr_n,
    input  logic                  link_active,
    lpif_ustrm_protid_arb_if.slave bus,
    output logic                  err_pkt_len,
    output logic [31:0]           arb_status
);
    arb_state_e            state_q, state_d;
    logic [1:0]            grant_q, grant_d, rr_ptr_q, rr_ptr_d, protid_q, protid_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  hold_q, hold_d, err_q, err_d;
    logic                  dvalid_q, dvalid_d, crc_valid_q, crc_valid_d, valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, sel_data;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d, sel_crc;
    logic [MAX_REQ-1:0]    valid_pad, last_pad, crcv_pad, ready_pad;
    logic                  ready_en, xfer, wd_hit, pkt_done, any_req;
    logic [1:0]            pick_ptr, pick_idx;

    assign valid_pad = MAX_REQ'(bus.req_valid);
    assign last_pad  = MAX_REQ'(bus.req_last);
    assign crcv_pad  = MAX_REQ'(bus.req_crc_valid);

    // hold_q inserts the single bubble after an immediate re-grant.
    assign ready_en  = (state_q == LOCKED) && link_active && !hold_q;
    assign ready_pad = ready_en ? (MAX_REQ'(1) << grant_q) : '0;
    assign bus.req_ready = NUM_REQ'(ready_pad);

    assign xfer     = ready_en && valid_pad[grant_q];
    assign wd_hit   = xfer && !last_pad[grant_q] && (beat_cnt_q == 8'(MAX_PKT_BEATS - 1));
    assign pkt_done = xfer && (last_pad[grant_q] || wd_hit);
    assign pick_ptr = (state_q == LOCKED) ? next_idx(grant_q, NUM_REQ) : rr_ptr_q;

    lpif_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req     (bus.req_valid & {NUM_REQ{link_active}}),
        .ptr     (pick_ptr),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        sel_data = '0;
        sel_crc  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (2'(i) == grant_q) begin
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_crc  = bus.req_crc[i*CRC_WIDTH +: CRC_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        hold_d      = 1'b0;
        err_d       = err_q | wd_hit;
        protid_d    = protid_q;
        data_d      = data_q;
        crc_d       = crc_q;
        crc_valid_d = 1'b0;
        dvalid_d    = 1'b0;
        valid_d     = link_active;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = LOCKED;
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
                end
                if (pkt_done) begin
                    rr_ptr_d = pick_ptr;
                    if (any_req) begin
                        grant_d    = pick_idx;
                        beat_cnt_d = '0;
                        hold_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            protid_d    = grant_q;
            data_d      = sel_data;
            crc_d       = sel_crc;
            crc_valid_d = crcv_pad[grant_q];
            dvalid_d    = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            hold_q      <= 1'b0;
            err_q       <= 1'b0;
            protid_q    <= '0;
            data_q      <= '0;
            crc_q       <= '0;
            crc_valid_q <= 1'b0;
            dvalid_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            protid_q    <= protid_d;
            data_q      <= data_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
            dvalid_q    <= dvalid_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.ustrm_protid    = protid_q;
    assign bus.ustrm_data      = data_q;
    assign bus.ustrm_dvalid    = dvalid_q;
    assign bus.ustrm_crc       = crc_q;
    assign bus.ustrm_crc_valid = crc_valid_q;
    assign bus.ustrm_valid     = valid_q;
    assign err_pkt_len         = err_q;

    always_comb begin
        arb_status = '0;
        arb_status[STAT_GRANT_LSB +: 2] = grant_q;
        arb_status[STAT_STATE_LSB +: 2] = state_q;
        arb_status[STAT_BCNT_LSB  +: 8] = beat_cnt_q;
    end
endmodule

// File: tb/tb_lpif_ustrm_protid_arb.sv
// Directed bench: a 4-requester build (watchdog at 4 beats) and a 2-requester build share clock, reset and link.
module tb_lpif_ustrm_protid_arb;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk_wr = 1'b0;
    logic rst_wr_n = 1'b0;
    logic link_active = 1'b0;
    logic link_nxt = 1'b0;
    logic err_a, err_b;
    logic [31:0] st_a, st_b;

    always #5 clk_wr = ~clk_wr;

    lpif_ustrm_protid_arb_if #(.NUM_REQ(4), .DATA_WIDTH(DW), .CRC_WIDTH(CW)) ifa ();
    lpif_ustrm_protid_arb_if #(.NUM_REQ(2), .DATA_WIDTH(DW), .CRC_WIDTH(CW)) ifb ();

    lpif_ustrm_protid_arb #(.NUM_REQ(4), .DATA_WIDTH(DW), .CRC_WIDTH(CW), .MAX_PKT_BEATS(4)) u_dut_a (
        .clk_wr      (clk_wr),
        .rst_wr_n    (rst_wr_n),
        .link_active (link_active),
        .bus         (ifa.slave),
        .err_pkt_len (err_a),
        .arb_status  (st_a)
    );

    lpif_ustrm_protid_arb #(.NUM_REQ(2), .DATA_WIDTH(DW), .CRC_WIDTH(CW), .MAX_PKT_BEATS(64)) u_dut_b (
        .clk_wr      (clk_wr),
        .rst_wr_n    (rst_wr_n),
        .link_active (link_active),
        .bus         (ifb.slave),
        .err_pkt_len (err_b),
        .arb_status  (st_b)
    );

    int n_cmp;
    int n_fail;
    int beat[4];
    int len[4];
    bit act[4];
    logic [3:0] rdy_snap;

    function automatic logic [31:0] dat(input int i, input int b);
        return 32'hA000_0000 | 32'((i << 8) | b);
    endfunction

    function automatic logic [7:0] crc8(input int i, input int b);
        return 8'(i * 16 + b + 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic dv, input int i, input int b);
        check({tag, ".dvalid"}, 64'(ifa.ustrm_dvalid), 64'(dv));
        if (dv) begin
            check({tag, ".protid"}, 64'(ifa.ustrm_protid), 64'(i));
            check({tag, ".data"}, 64'(ifa.ustrm_data), 64'(dat(i, b)));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            ifa.req_valid[i]     = act[i];
            ifa.req_last[i]      = act[i] && (beat[i] == len[i] - 1);
            ifa.req_crc_valid[i] = act[i] && (beat[i] == len[i] - 1);
            ifa.req_data[i*DW +: DW] = dat(i, beat[i]);
            ifa.req_crc[i*CW +: CW]  = crc8(i, beat[i]);
        end
    endtask

    // Advance each requester past a beat accepted in the previous cycle, then sample mid-cycle.
    task automatic step();
        @(posedge clk_wr);
        #1;
        link_active = link_nxt;
        for (int i = 0; i < 4; i++) begin
            if (rdy_snap[i] && act[i]) beat[i] = (beat[i] == len[i] - 1) ? 0 : beat[i] + 1;
        end
        drive();
        @(negedge clk_wr);
        rdy_snap = ifa.req_ready;
    endtask

    task automatic start();
        rst_wr_n = 1'b0;
        link_nxt = 1'b0;
        link_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0;
            beat[i] = 0;
            len[i] = 1;
        end
        rdy_snap = '0;
        drive();
        repeat (2) @(posedge clk_wr);
        #1;
        rst_wr_n = 1'b1;
    endtask

    task automatic settle();
        link_active = link_nxt;
        drive();
        @(negedge clk_wr);
        rdy_snap = ifa.req_ready;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        ifb.req_valid     = 2'b11;
        ifb.req_last      = 2'b11;
        ifb.req_crc_valid = 2'b00;
        ifb.req_data      = {32'h0000_00B1, 32'h0000_00B0};
        ifb.req_crc       = '0;

        // Reset state, then no grant while the link is down.
        start();
        settle();
        check("rst.dvalid", 64'(ifa.ustrm_dvalid), 64'd0);
        check("rst.data", 64'(ifa.ustrm_data), 64'd0);
        check("rst.crc_valid", 64'(ifa.ustrm_crc_valid), 64'd0);
        check("rst.valid", 64'(ifa.ustrm_valid), 64'd0);
        check("rst.err", 64'(err_a), 64'd0);
        check("rst.status", 64'(st_a), 64'd0);
        check("rst.ready", 64'(ifa.req_ready), 64'd0);
        act[0] = 1'b1;
        step();
        check("nolink.ready", 64'(ifa.req_ready), 64'd0);
        check("nolink.status", 64'(st_a), 64'd0);

        // Single requester, 3-beat packet.
        start();
        link_nxt = 1'b1;
        act[0] = 1'b1;
        len[0] = 3;
        settle();
        check("single.c0.ready", 64'(ifa.req_ready), 64'd0);
        step();
        check("single.c1.ready", 64'(ifa.req_ready), 64'h1);
        check("single.c1.valid", 64'(ifa.ustrm_valid), 64'd1);
        check("single.c1.status", 64'(st_a), 64'h1000_0000);
        chk_beat("single.c1", 1'b0, 0, 0);
        step();
        chk_beat("single.c2", 1'b1, 0, 0);
        check("single.c2.crc_valid", 64'(ifa.ustrm_crc_valid), 64'd0);
        step();
        chk_beat("single.c3", 1'b1, 0, 1);
        step();
        chk_beat("single.c4", 1'b1, 0, 2);
        check("single.c4.crc_valid", 64'(ifa.ustrm_crc_valid), 64'd1);
        check("single.c4.crc", 64'(ifa.ustrm_crc), 64'(crc8(0, 2)));
        check("single.c4.ready", 64'(ifa.req_ready), 64'd0);
        act[0] = 1'b0;
        step();
        chk_beat("single.c5", 1'b0, 0, 0);
        check("single.c5.crc_valid", 64'(ifa.ustrm_crc_valid), 64'd0);
        check("single.c5.hold_data", 64'(ifa.ustrm_data), 64'(dat(0, 2)));
        check("single.c5.ready", 64'(ifa.req_ready), 64'h1);

        // Fairness: four requesters, 2-beat packets, one bubble per packet.
        start();
        link_nxt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b1;
            len[i] = 2;
        end
        settle();
        for (int k = 1; k <= 15; k++) begin
            int m;
            m = k - 1;
            step();
            chk_beat($sformatf("fair.c%0d", k), (m % 3) != 0, (m / 3) % 4, (m % 3) - 1);
            check($sformatf("fair.c%0d.ready", k), 64'(ifa.req_ready),
                  (m % 3 == 2) ? 64'd0 : 64'(1 << ((m / 3) % 4)));
        end

        // Link drop after beat 1 of 4 from requester 2.
        start();
        link_nxt = 1'b1;
        act[2] = 1'b1;
        len[2] = 4;
        settle();
        step();
        check("drop.c1.ready", 64'(ifa.req_ready), 64'h4);
        link_nxt = 1'b0;
        step();
        chk_beat("drop.c2", 1'b1, 2, 0);
        check("drop.c2.ready", 64'(ifa.req_ready), 64'd0);
        check("drop.c2.status", 64'(st_a), 64'h9010_0000);
        for (int k = 3; k <= 6; k++) begin
            step();
            chk_beat($sformatf("drop.c%0d", k), 1'b0, 0, 0);
            check($sformatf("drop.c%0d.ready", k), 64'(ifa.req_ready), 64'd0);
            check($sformatf("drop.c%0d.valid", k), 64'(ifa.ustrm_valid), 64'd0);
        end
        check("drop.c6.status", 64'(st_a), 64'h9010_0000);
        link_nxt = 1'b1;
        step();
        chk_beat("drop.c7", 1'b0, 0, 0);
        check("drop.c7.ready", 64'(ifa.req_ready), 64'h4);
        step();
        chk_beat("drop.c8", 1'b1, 2, 1);
        check("drop.c8.valid", 64'(ifa.ustrm_valid), 64'd1);
        step();
        chk_beat("drop.c9", 1'b1, 2, 2);
        step();
        chk_beat("drop.c10", 1'b1, 2, 3);
        check("drop.c10.crc_valid", 64'(ifa.ustrm_crc_valid), 64'd1);
        check("drop.c10.err", 64'(err_a), 64'd0);

        // Watchdog: requester 1 never ends its packet; requester 3 is waiting.
        start();
        link_nxt = 1'b1;
        act[1] = 1'b1;
        len[1] = 100;
        act[3] = 1'b1;
        len[3] = 2;
        settle();
        step();
        check("wd.c1.ready", 64'(ifa.req_ready), 64'h2);
        step();
        chk_beat("wd.c2", 1'b1, 1, 0);
        step();
        chk_beat("wd.c3", 1'b1, 1, 1);
        step();
        chk_beat("wd.c4", 1'b1, 1, 2);
        check("wd.c4.err", 64'(err_a), 64'd0);
        check("wd.c4.status", 64'(st_a), 64'h5030_0000);
        step();
        chk_beat("wd.c5", 1'b1, 1, 3);
        check("wd.c5.err", 64'(err_a), 64'd1);
        check("wd.c5.status", 64'(st_a), 64'hD000_0000);
        step();
        chk_beat("wd.c6", 1'b0, 0, 0);
        check("wd.c6.ready", 64'(ifa.req_ready), 64'h8);
        step();
        chk_beat("wd.c7", 1'b1, 3, 0);
        step();
        chk_beat("wd.c8", 1'b1, 3, 1);
        step();
        check("wd.c9.ready", 64'(ifa.req_ready), 64'h2);
        check("wd.c9.err", 64'(err_a), 64'd1);

        // Reset during beat 2 of requester 1 after the pointer has moved to 1.
        start();
        link_nxt = 1'b1;
        act[0] = 1'b1;
        len[0] = 2;
        act[1] = 1'b1;
        len[1] = 3;
        settle();
        repeat (4) step();
        check("rmid.c4.ready", 64'(ifa.req_ready), 64'h2);
        step();
        chk_beat("rmid.c5", 1'b1, 1, 0);
        rst_wr_n = 1'b0;
        step();
        check("rmid.dvalid", 64'(ifa.ustrm_dvalid), 64'd0);
        check("rmid.data", 64'(ifa.ustrm_data), 64'd0);
        check("rmid.protid", 64'(ifa.ustrm_protid), 64'd0);
        check("rmid.crc", 64'(ifa.ustrm_crc), 64'd0);
        check("rmid.valid", 64'(ifa.ustrm_valid), 64'd0);
        check("rmid.err", 64'(err_a), 64'd0);
        check("rmid.status", 64'(st_a), 64'd0);
        check("rmid.ready", 64'(ifa.req_ready), 64'd0);
        rst_wr_n = 1'b1;
        for (int i = 0; i < 4; i++) beat[i] = 0;
        rdy_snap = '0;
        drive();
        step();
        check("rmid.ptr0.ready", 64'(ifa.req_ready), 64'h1);
        check("rmid.ptr0.status", 64'(st_a), 64'h1000_0000);

        // Two-requester build: single-beat packets alternate protid 0,1.
        start();
        link_nxt = 1'b1;
        settle();
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("nr2.c%0d.dvalid", k), 64'(ifb.ustrm_dvalid), 64'((k % 2) == 0));
            check($sformatf("nr2.c%0d.protid_hi", k), 64'(ifb.ustrm_protid[1]), 64'd0);
            if ((k % 2) == 0) begin
                check($sformatf("nr2.c%0d.protid", k), 64'(ifb.ustrm_protid), 64'(((k / 2) - 1) % 2));
                check($sformatf("nr2.c%0d.data", k), 64'(ifb.ustrm_data),
                      (((k / 2) - 1) % 2) == 1 ? 64'hB1 : 64'hB0);
            end
        end
        check("nr2.err", 64'(err_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
